// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2 / stride-2 max pooling over a raster-ordered
// IN_SIZE x IN_SIZE feature map. One half-row line buffer holds the horizontal
// pair maxima of each even row until the matching odd row arrives.
// Optional build macro: MAXPOOL_RELU_EN fuses a ReLU on the registered output.
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_SIZE    = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic                         frame_done
);

  localparam int HALF = IN_SIZE / 2;
  localparam int CW   = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);
  // Last odd coordinate that closes a full 2x2 window (drops a trailing odd line).
  localparam logic [CW-1:0] LAST_ODD = CW'(2 * HALF - 1);

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] out_act(
    input logic signed [DATA_WIDTH-1:0] a
  );
`ifdef MAXPOOL_RELU_EN
    // max and ReLU commute, so clamping once at the output is exact.
    return (a < 0) ? '0 : a;
`else
    return a;
`endif
  endfunction

  logic [CW-1:0]                 col_q, col_d;
  logic [CW-1:0]                 row_q, row_d;
  logic signed [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic signed [DATA_WIDTH-1:0]  linebuf [HALF];
  logic signed [DATA_WIDTH-1:0]  pair_max;
  logic [AW-1:0]                 lb_idx;
  logic                          lb_we;

  // Next-state: raster counters, horizontal pair max, line-buffer write, output.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_idx       = AW'(col_q >> 1);
    pair_max     = smax(hold_q, in_data);
    if (in_valid) begin
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_data_d   = out_act(smax(linebuf[lb_idx], pair_max));
        out_valid_d  = 1'b1;
        frame_done_d = (row_q == LAST_ODD) && (col_q == LAST_ODD);
      end
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer of even-row pair maxima; always written before it is read.
  always_ff @(posedge clk) begin
    if (lb_we && !reset) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: three instances (sides 4, 5, 24) share clock and
// reset. A map-level model recomputes every 2x2 window maximum from the stored
// input map and is compared against the outputs every cycle; literal sequences
// pin the expected pooled values of the directed maps.
module tb_maxpool_2x2_stream;

  logic clk;
  logic reset;
  logic                iv [3];
  logic signed [15:0]  id [3];
  logic signed [15:0]  od [3];
  logic                ov [3];
  logic                fd [3];

  int total = 0;
  int bad   = 0;

  maxpool_2x2_stream #(.DATA_WIDTH(16), .IN_SIZE(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_data(id[0]),
    .out_data(od[0]), .out_valid(ov[0]), .frame_done(fd[0]));
  maxpool_2x2_stream #(.DATA_WIDTH(16), .IN_SIZE(5)) u5 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_data(id[1]),
    .out_data(od[1]), .out_valid(ov[1]), .frame_done(fd[1]));
  maxpool_2x2_stream #(.DATA_WIDTH(16), .IN_SIZE(24)) u24 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_data(id[2]),
    .out_data(od[2]), .out_valid(ov[2]), .frame_done(fd[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int                 side [3] = '{4, 5, 24};
  int                 pos  [3] = '{0, 0, 0};
  logic signed [15:0] map  [3][24][24];
  logic               exp_v [3] = '{0, 0, 0};
  logic               exp_f [3] = '{0, 0, 0};
  logic signed [15:0] exp_d [3] = '{0, 0, 0};
  logic               chk_en = 1'b0;

  function automatic logic signed [15:0] act(input logic signed [15:0] a);
`ifdef MAXPOOL_RELU_EN
    return (a < 0) ? 16'sd0 : a;
`else
    return a;
`endif
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int r, c, w;
      logic signed [15:0] m;
      exp_v[k] = 1'b0;
      exp_f[k] = 1'b0;
      if (reset) begin
        pos[k]   = 0;
        exp_d[k] = 16'sd0;
      end else if (iv[k]) begin
        r = pos[k] / side[k];
        c = pos[k] % side[k];
        w = 2 * (side[k] / 2);
        map[k][r][c] = id[k];
        if ((r % 2 == 1) && (c % 2 == 1) && r < w && c < w) begin
          m = map[k][r-1][c-1];
          if (map[k][r-1][c] > m) m = map[k][r-1][c];
          if (map[k][r][c-1] > m) m = map[k][r][c-1];
          if (map[k][r][c]   > m) m = map[k][r][c];
          exp_v[k] = 1'b1;
          exp_d[k] = act(m);
          exp_f[k] = (r == w - 1) && (c == w - 1);
        end
        pos[k] = (pos[k] + 1) % (side[k] * side[k]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic signed [15:0] gq [$];
  logic               gf [$];
  int                 fdcnt = 0;

  task automatic cmp(input string nm, input int act_v, input int req_v);
    total++;
    if (act_v !== req_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act_v, req_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        cmp($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(exp_v[k]));
        cmp($sformatf("frame_done[%0d]", k), int'(fd[k]), int'(exp_f[k]));
        cmp($sformatf("out_data[%0d]", k), int'(od[k]), int'(exp_d[k]));
        if (ov[k] === 1'b1) begin
          gq.push_back(od[k]);
          gf.push_back(fd[k]);
        end
        if (fd[k] === 1'b1) fdcnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int k, input int v, input int gap);
    iv[k] = 1'b1;
    id[k] = 16'(v);
    tick(1);
    iv[k] = 1'b0;
    tick(gap);
  endtask

  task automatic clear_log();
    gq.delete();
    gf.delete();
    fdcnt = 0;
  endtask

  task automatic check_q(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    cmp({nm, " count"}, gq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) cmp($sformatf("%s[%0d]", nm, i), int'(gq[i]), e[i]);
    end
    cmp({nm, " frame_done count"}, fdcnt, 1);
    if (gf.size() == 4) cmp({nm, " frame_done on last"}, int'(gf[3]), 1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      id[k] = 16'sd0;
    end
    reset = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    cmp("reset out_data", int'(od[0]), 0);
    cmp("reset out_valid", int'(ov[0]), 0);
    reset = 1'b0;
    tick(2);

    // ramp 0..15, continuous
    clear_log();
    for (int i = 0; i < 16; i++) send(0, i, 0);
    tick(3);
    check_q("ramp4", 5, 7, 13, 15);

    // all -3 except -1 at (1,0)
    clear_log();
    for (int i = 0; i < 16; i++) send(0, (i == 4) ? -1 : -3, 0);
    tick(3);
`ifdef MAXPOOL_RELU_EN
    check_q("neg4", 0, 0, 0, 0);
`else
    check_q("neg4", -1, -3, -3, -3);
`endif

    // ramp with random gaps
    clear_log();
    for (int i = 0; i < 16; i++) send(0, i, (i % 2 == 0) ? 1 : $urandom_range(0, 5));
    tick(3);
    check_q("gap4", 5, 7, 13, 15);

    // odd size 5, two back-to-back maps
    for (int f = 0; f < 2; f++) begin
      clear_log();
      for (int i = 0; i < 25; i++) send(1, i, 0);
      tick(3);
      check_q($sformatf("odd5_map%0d", f), 6, 8, 16, 18);
    end

    // reset mid-map, sample presented during reset is dropped
    for (int i = 0; i < 9; i++) send(0, i, 0);
    reset = 1'b1;
    iv[0] = 1'b1;
    id[0] = 16'sd50;
    tick(2);
    cmp("midreset out_data", int'(od[0]), 0);
    cmp("midreset out_valid", int'(ov[0]), 0);
    iv[0] = 1'b0;
    reset = 1'b0;
    tick(1);
    clear_log();
    for (int i = 0; i < 16; i++) send(0, 100 + i, 0);
    tick(3);
    check_q("after_reset", 105, 107, 113, 115);

    // two back-to-back random 24x24 maps
    clear_log();
    for (int i = 0; i < 2 * 576; i++) send(2, int'($signed(16'($urandom))), 0);
    tick(3);
    cmp("big outputs", gq.size(), 288);
    cmp("big frame_done pulses", fdcnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2×2, stride-2 max-pooling stage directly downstream of `convolver_complex`. It consumes the convolver's raster-ordered result stream (`conv_final_result` qualified by `enable_signal`) for one IN_SIZE×IN_SIZE feature map and emits the (IN_SIZE/2)×(IN_SIZE/2) pooled map in raster order. A single line buffer of IN_SIZE/2 partial maxima keeps storage to one half-row.

## Interface
- `DATA_WIDTH`, 16: sample width, signed two's complement, same fixed-point format as the convolver output.
- `IN_SIZE`, 24: input map side (IMAGE_SIZE − KERNEL_SIZE + 1 for the 28/5 configuration); must be ≥ 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: input sample strobe; connect to convolver `enable_signal`.
- `in_data` input DATA_WIDTH, signed: input sample; connect to `conv_final_result`.
- `out_data` output DATA_WIDTH, signed: pooled value.
- `out_valid` output 1: `out_data` valid, one-cycle pulse per pooled value.
- `frame_done` output 1: one-cycle pulse coincident with the last pooled value of a map.

## Operation
- Counters `col`, `row`, range 0..IN_SIZE−1; advance only on cycles with `in_valid`=1; `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last column of the last row (start of next map, no idle cycle required).
- Horizontal pair: even `col` → `hold <= in_data`; odd `col` → pair max `m = max(hold, in_data)`, signed compare.
- Even `row`, odd `col`: `linebuf[col>>1] <= m`; no output.
- Odd `row`, odd `col`: `out_data <= max(linebuf[col>>1], m)`; `out_valid <= 1`.
- Ties: either operand; values equal, result identical.
- Odd IN_SIZE: trailing column (col = IN_SIZE−1) and trailing row are consumed by the counters but contribute to no output (floor semantics). Output map side = floor(IN_SIZE/2).
- `frame_done <= 1` together with the output generated at the last odd row / last odd column pair.
- Gaps in `in_valid` of any length are allowed at any position; state is held.
- No backpressure: downstream must accept every `out_valid` pulse.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `frame_done`=0, `col`=0, `row`=0, `hold`=0. `linebuf` is not reset; it is always written before it is read.
- Latency: `out_valid` rises the cycle after the rising edge that samples the completing input (odd row, odd col); one register stage.
- Output throughput: at most one output every 2 accepted inputs, and only during odd rows.
- `reset` asserted mid-map: next edge clears counters and outputs; any partial map is discarded; the first `in_valid` after reset deasserts is treated as (row 0, col 0).
- `reset` and `in_valid` in the same cycle: reset wins; sample dropped.
- `out_valid`/`frame_done` deassert the cycle after a pulse unless another output completes.

## Configuration
- `MAXPOOL_RELU_EN` defined: ReLU fused at the output; a negative pooled result is replaced by 0 before registering `out_data` (max and ReLU commute, so applying it once at the output is exact).
- Not defined: `out_data` is the raw signed maximum, negatives passed through.

## Test plan
- IN_SIZE=4, continuous `in_valid`, inputs 0..15 in raster order → outputs 5, 7, 13, 15; `out_valid` one cycle after inputs 5, 7, 13, 15 are sampled; `frame_done` with 15.
- IN_SIZE=4, all inputs −3 except −1 at (1,0) → outputs −1, −3, −3, −3 without macro; 0, 0, 0, 0 with `MAXPOOL_RELU_EN`.
- IN_SIZE=4 stream of the first test with `in_valid` toggling 1/0 and random 0–5 cycle gaps → identical output values and order; no spurious `out_valid`.
- IN_SIZE=5, inputs 0..24 → outputs 6, 8, 16, 18; column 4 and row 4 ignored; `frame_done` with 18; next map starts correctly.
- Reset asserted after 9 inputs of a 4×4 map, then a full map of 100..115 → outputs 105, 107, 113, 115 only; all outputs 0 during reset.
- Two back-to-back 24×24 maps of random signed values checked against a reference model → 144 outputs each, exactly two `frame_done` pulses.
